// File: rtl/aes_key_schedule_seq_if.sv
// Key-load handshake, status and round-key read port of the AES-128 key schedule.
// The cipher side is the master; the key schedule is the slave.
interface aes_key_schedule_seq_if;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         busy;
    logic         keys_valid;
    logic         done;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    modport master (
        output key_in, key_valid, rd_idx,
        input  key_ready, busy, keys_valid, done, rd_key
    );

    modport slave (
        input  key_in, key_valid, rd_idx,
        output key_ready, busy, keys_valid, done, rd_key
    );
endinterface

// File: rtl/aes_key_schedule_seq.sv
// Sequential AES-128 key expansion: one round key per cycle into an 11-slot bank,
// served through a registered read port.

module aes_key_generation (
    input  logic [127:0] key,
    input  logic [3:0]   rc,
    output logic [127:0] keyout
);
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte of the packed table.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] msb;
        msb = 11'd2047 - {b, 3'b000};
        return SBOX_TBL[msb -: 8];
    endfunction

    logic [7:0]  rcon;
    logic [31:0] rot_w;
    logic [31:0] temp_w;
    logic [31:0] n0, n1, n2, n3;

    always_comb begin
        unique case (rc)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        rot_w  = {key[23:0], key[31:24]};
        temp_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])}
                 ^ {rcon, 24'h000000};
        n0     = key[127:96] ^ temp_w;
        n1     = key[95:64]  ^ n0;
        n2     = key[63:32]  ^ n1;
        n3     = key[31:0]   ^ n2;
        keyout = {n0, n1, n2, n3};
    end
endmodule

// state   | meaning
// S_IDLE  | no schedule held since reset, ready for a key
// S_EXPAND| generating round keys 1..NR, one per cycle
// S_READY | bank holds the full schedule of the last key
module aes_key_schedule_seq #(
    parameter int NR = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_key_schedule_seq_if.slave ks
);
    localparam logic [3:0] LAST_RND = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXPAND = 2'd1,
        S_READY  = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [3:0]   rcnt_q, rcnt_d;
    logic [127:0] cur_q, cur_d;
    logic [127:0] bank_q [0:NR];
    logic [127:0] bank_d [0:NR];
    logic [127:0] rd_key_q, rd_key_d;
    logic         keys_valid_q, keys_valid_d;
    logic         done_q, done_d;

    logic         key_ready;
    logic         busy;
    logic         accept;
    logic         last_rnd;
    logic [3:0]   kg_rc;
    logic [127:0] keyout;

    aes_key_generation u_keygen (
        .key    (cur_q),
        .rc     (kg_rc),
        .keyout (keyout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_READY: if (ks.key_valid) state_d = S_EXPAND;
            S_EXPAND:        if (last_rnd)     state_d = S_READY;
            default:         state_d = S_IDLE;
        endcase
    end

    always_comb begin
        key_ready = (state_q != S_EXPAND);
        busy      = (state_q == S_EXPAND);
        accept    = key_ready && ks.key_valid;
        last_rnd  = busy && (rcnt_q == LAST_RND);
        // Outside EXPAND the generator output is unused; keep rc off the zero rcon.
        kg_rc     = busy ? rcnt_q : 4'd1;
    end

    always_comb begin
        rcnt_d       = rcnt_q;
        cur_d        = cur_q;
        bank_d       = bank_q;
        keys_valid_d = keys_valid_q;
        done_d       = 1'b0;
        if (accept) begin
            bank_d[0]    = ks.key_in;
            cur_d        = ks.key_in;
            rcnt_d       = 4'd1;
            keys_valid_d = 1'b0;
        end else if (busy) begin
            for (int i = 1; i <= NR; i++) begin
                if (rcnt_q == 4'(i)) bank_d[i] = keyout;
            end
            cur_d = keyout;
            if (last_rnd) begin
                keys_valid_d = 1'b1;
                done_d       = 1'b1;
            end else begin
                rcnt_d = rcnt_q + 4'd1;
            end
        end
    end

    // Read port samples the bank before this edge's write lands.
    always_comb begin
        rd_key_d = '0;
        for (int i = 0; i <= NR; i++) begin
            if (ks.rd_idx == 4'(i)) rd_key_d = bank_q[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt_q       <= 4'd0;
            cur_q        <= '0;
            bank_q       <= '{default: '0};
            rd_key_q     <= '0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            rcnt_q       <= rcnt_d;
            cur_q        <= cur_d;
            bank_q       <= bank_d;
            rd_key_q     <= rd_key_d;
            keys_valid_q <= keys_valid_d;
            done_q       <= done_d;
        end
    end

    assign ks.key_ready  = key_ready;
    assign ks.busy       = busy;
    assign ks.keys_valid = keys_valid_q;
    assign ks.done       = done_q;
    assign ks.rd_key     = rd_key_q;
endmodule

// File: doc/aes_key_schedule_seq.md
Name: aes_key_schedule_seq

Overview:
- Sequential AES-128 key-expansion controller wrapped around one instance of the combinational KeyGeneration round-key block.
- Accepts a 128-bit cipher key and drives KeyGeneration once per cycle with rc = 1..10, feeding each keyout back as the next key input.
- Stores all 11 round keys (slot 0 = cipher key) in a register bank.
- Serves the bank to the downstream cipher round datapath through a registered read port.

Parameters:
- NR, 10, number of expansion rounds; fixed for AES-128; values other than 10 unsupported.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- key_in  input  128  cipher key, bit 127 = first byte; sampled on handshake.
- key_valid  input  1  key_in valid.
- key_ready  output  1  block can accept a key.
- busy  output  1  expansion in progress.
- keys_valid  output  1  all 11 slots hold the schedule of the last accepted key.
- done  output  1  one-cycle pulse when expansion completes.
- rd_idx  input  4  round-key slot to read, 0..10.
- rd_key  output  128  registered read data.

Behaviour:
- State machine with three states: IDLE, EXPAND, READY.
- Reset (async assert, any state):
  - state=IDLE, round counter rcnt=0, working register cur=0, all 11 bank slots=0.
  - rd_key=0, busy=0, keys_valid=0, done=0.
  - key_ready=1 whenever state is IDLE or READY; it is 1 during and after reset.
- Handshake:
  - Accept occurs on a rising edge with key_valid=1 and key_ready=1.
  - key_ready is decoded from state only; no combinational path from key_valid.
  - key_valid while key_ready=0 (EXPAND) is ignored, not queued.
- On accept (edge A):
  - slot0 <= key_in, cur <= key_in, rcnt <= 1, state <= EXPAND, keys_valid <= 0.
- EXPAND, each edge:
  - KeyGeneration sees key=cur, rc=rcnt.
  - slot[rcnt] <= keyout, cur <= keyout.
  - If rcnt==10: state <= READY, keys_valid <= 1, done <= 1 for one cycle. Otherwise rcnt <= rcnt+1.
- Latency:
  - Slot k is written at edge A+k.
  - keys_valid and done are high after edge A+10, i.e. 10 cycles after accept.
  - done is high for exactly the cycle after edge A+10.
- busy = (state==EXPAND).
- rcnt stays in 1..10 during EXPAND; rc=0 is never driven to KeyGeneration (rcon 0).
- READY:
  - Holds the bank and keys_valid=1 until a new key is accepted.
  - A new accept in READY behaves as from IDLE, and keys_valid falls on that same edge.
- Read port:
  - rd_key <= slot[rd_idx] every edge, so data appears 1 cycle after rd_idx is applied.
  - rd_idx 11..15 returns 0.
  - Reads are allowed in any state. During EXPAND they return current bank contents, which may be stale or partial; consumers must qualify with keys_valid.
  - A read of slot k on edge A+k returns the pre-write value (no write-through).
- Reset mid-EXPAND: everything returns to reset values immediately, and the bank is cleared. The next key restarts from rcnt=1.
- Simultaneous key_valid and rst: rst wins; no key is accepted.

Test Plan:
- FIPS-197 vector:
  - Stimulus: accept key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - Required: done pulses 10 cycles later, keys_valid=1.
  - Required: rd_idx=1 gives a0fafe1788542cb123a339392a6c7605.
  - Required: rd_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Required: rd_idx=0 returns the key itself.
- Busy rejection:
  - Stimulus: second key_valid with key 000102030405060708090a0b0c0d0e0f asserted throughout EXPAND.
  - Required: key_ready=0 for the full EXPAND period and busy=1 for exactly 10 cycles.
  - Required: slot 10 = d014f9a8…, unaffected by the second key.
  - Required: the second key is accepted on the first cycle in READY.
- Rekey from READY:
  - Stimulus: after the vector above, accept all-zero key.
  - Required: keys_valid drops on the accept edge.
  - Required: 10 cycles later slot 1 = 62636363626363636263636362636363 and slot 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Reset mid-expansion:
  - Stimulus: assert rst 5 cycles after accept, asynchronously between edges.
  - Required: busy/keys_valid/done drop immediately, rd_key=0, and every slot reads 0 afterwards.
  - Required: a fresh accept then reproduces the FIPS result.
- Read port:
  - Stimulus: sweep rd_idx 0..15 in READY.
  - Required: each value appears exactly 1 cycle later; indices 11..15 return 0.
  - Required: a read of slot k during EXPAND on edge A+k returns the old value.
- Back-to-back keys:
  - Stimulus: hold key_valid high continuously.
  - Required: an accept every 11 cycles (1 accept cycle + 10 EXPAND cycles), with exactly one done pulse per key.
